// File: rtl/multdiv_param_if.sv
// Operand/control/result bundle for the iterative multiply/divide unit.
//
// Handshake: the master pulses ctrl_MULT or ctrl_DIV for one cycle with the
// operands valid in that same cycle. The unit samples them on that rising
// edge and raises busy. There is no ready/back-pressure: a new start is
// always accepted and silently aborts any operation in flight. Completion
// is a single-cycle data_resultRDY pulse. data_result, data_result_hi and
// data_exception are valid in that cycle and hold until the next start.
interface multdiv_param_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_result_hi;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_result_hi, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_result_hi, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_param.sv
// Parametrised iterative signed multiplier / divider.
// Works on operand magnitudes: radix-2 shift-add multiply and restoring
// divide, one iteration per clock for WIDTH clocks, followed by a
// sign-correction edge that registers the results and enters DONE.
module multdiv_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic           clock,
    input  logic           reset_n,
    multdiv_param_if.slave bus,
    output logic [1:0]     dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             start;
    logic             busy_int;
    logic             rdy_int;
    logic             iter_done;
    logic [CNT_W-1:0] cnt_q;

    // hi_q/lo_q: product halves (multiply) or remainder/quotient (divide)
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opb_q;
    logic             neg_q;
    logic             rem_neg_q;
    logic             dvz_q;

    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_hi_q;
    logic             exc_q;

    logic             a_sign;
    logic             b_sign;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_signed;
    logic               mul_ovf;
    logic               div_ovf;

    assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
    assign iter_done = (cnt_q == CNT_W'(WIDTH));

    // MIN_INT negates to itself, which is the correct unsigned magnitude
    assign a_sign = bus.data_operandA[WIDTH-1];
    assign b_sign = bus.data_operandB[WIDTH-1];
    assign a_mag  = a_sign ? -bus.data_operandA : bus.data_operandA;
    assign b_mag  = b_sign ? -bus.data_operandB : bus.data_operandB;

    // One iteration of each algorithm, plus the final sign correction
    assign mul_sum     = {1'b0, hi_q} + {1'b0, opb_q};
    assign div_shift   = {hi_q, lo_q[WIDTH-1]};
    assign div_diff    = div_shift - {1'b0, opb_q};
    assign prod_mag    = {hi_q, lo_q};
    assign prod_signed = neg_q ? -prod_mag : prod_mag;
    assign quo_signed  = neg_q ? -lo_q : lo_q;
    assign rem_signed  = rem_neg_q ? -hi_q : hi_q;
    assign mul_ovf     = (prod_signed[2*WIDTH-1:WIDTH] != {WIDTH{prod_signed[WIDTH-1]}});
    // A positive quotient with magnitude 2^(WIDTH-1) only arises from MIN_INT / -1
    assign div_ovf     = ~neg_q & lo_q[WIDTH-1];

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a start always wins, multiply has priority over divide
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = bus.ctrl_MULT ? S_MULT : S_DIV;
        end else begin
            case (state_q)
                S_MULT, S_DIV: if (iter_done) state_d = S_DONE;
                S_DONE:        state_d = S_IDLE;
                default:       state_d = state_q;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        busy_int  = 1'b0;
        rdy_int   = 1'b0;
        dbg_state = state_q;
        case (state_q)
            S_MULT, S_DIV: busy_int = 1'b1;
            S_DONE:        rdy_int  = 1'b1;
            default:       ;
        endcase
    end

    // Datapath: load on start, iterate while busy, register results on the final edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dvz_q     <= 1'b0;
            res_q     <= '0;
            res_hi_q  <= '0;
            exc_q     <= 1'b0;
        end else if (start) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= a_mag;
            opb_q     <= b_mag;
            neg_q     <= a_sign ^ b_sign;
            rem_neg_q <= a_sign;
            dvz_q     <= (bus.data_operandB == '0);
            exc_q     <= 1'b0;
        end else if (busy_int && !iter_done) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (state_q == S_MULT) begin
                if (lo_q[0]) begin
                    hi_q <= mul_sum[WIDTH:1];
                    lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
                end else begin
                    hi_q <= {1'b0, hi_q[WIDTH-1:1]};
                    lo_q <= {hi_q[0], lo_q[WIDTH-1:1]};
                end
            end else begin
                if (!div_diff[WIDTH]) begin
                    hi_q <= div_diff[WIDTH-1:0];
                    lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_q <= div_shift[WIDTH-1:0];
                    lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                end
            end
        end else if (busy_int) begin
            if (state_q == S_MULT) begin
                res_q    <= prod_signed[WIDTH-1:0];
                res_hi_q <= prod_signed[2*WIDTH-1:WIDTH];
                exc_q    <= mul_ovf;
            end else if (dvz_q) begin
                res_q    <= '0;
                res_hi_q <= '0;
                exc_q    <= 1'b1;
            end else begin
                res_q    <= quo_signed;
                res_hi_q <= rem_signed;
                exc_q    <= div_ovf;
            end
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_result_hi = res_hi_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_int;
    assign bus.busy           = busy_int;

endmodule

// File: tb/tb_multdiv_param.sv
// Bench for multdiv_param: a 32-bit and an 8-bit instance share clock and
// reset. Expected results come from a signed-integer model of multiply and
// divide (64-bit arithmetic, truncating division).
module tb_multdiv_param;

    logic       clock;
    logic       reset_n;
    logic [1:0] dbg32;
    logic [1:0] dbg8;

    int n_checks = 0;
    int n_fail   = 0;

    multdiv_param_if #(.WIDTH(32)) bus32 ();
    multdiv_param_if #(.WIDTH(8))  bus8 ();

    multdiv_param #(.WIDTH(32)) dut32 (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus32.slave),
        .dbg_state (dbg32)
    );

    multdiv_param #(.WIDTH(8)) dut8 (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus8.slave),
        .dbg_state (dbg8)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- accessors ----------------
    function automatic logic get_rdy(input bit w8);
        return w8 ? bus8.data_resultRDY : bus32.data_resultRDY;
    endfunction

    function automatic logic get_busy(input bit w8);
        return w8 ? bus8.busy : bus32.busy;
    endfunction

    function automatic logic get_exc(input bit w8);
        return w8 ? bus8.data_exception : bus32.data_exception;
    endfunction

    function automatic logic [31:0] get_res(input bit w8);
        return w8 ? {24'd0, bus8.data_result} : bus32.data_result;
    endfunction

    function automatic logic [31:0] get_hi(input bit w8);
        return w8 ? {24'd0, bus8.data_result_hi} : bus32.data_result_hi;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input bit w8, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            bus8.ctrl_MULT     = m;
            bus8.ctrl_DIV      = d;
            bus8.data_operandA = a[7:0];
            bus8.data_operandB = b[7:0];
        end else begin
            bus32.ctrl_MULT     = m;
            bus32.ctrl_DIV      = d;
            bus32.data_operandA = a;
            bus32.data_operandB = b;
        end
    endtask

    // Reference: signed integer arithmetic on sign-extended operands
    task automatic model(input bit w8, input bit is_mult,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [31:0] hi,
                         output logic exc);
        longint sa, sb, p, ph, q, r, lim;
        logic [31:0] mask;
        int w;
        w    = w8 ? 8 : 32;
        mask = w8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
        sa   = w8 ? longint'($signed(a[7:0])) : longint'($signed(a));
        sb   = w8 ? longint'($signed(b[7:0])) : longint'($signed(b));
        lim  = longint'(1) << (w - 1);
        if (is_mult) begin
            p   = sa * sb;
            ph  = p >>> w;
            res = p[31:0] & mask;
            hi  = ph[31:0] & mask;
            exc = (p >= lim) || (p < -lim);
        end else if (sb == 0) begin
            res = 32'd0;
            hi  = 32'd0;
            exc = 1'b1;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            res = q[31:0] & mask;
            hi  = r[31:0] & mask;
            exc = (q >= lim);
        end
    endtask

    // Wait for the completion pulse, counting edges after the start edge
    task automatic wait_rdy(input bit w8, input string tag, output int edges);
        bit seen;
        int k;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 80) begin
            @(posedge clock);
            @(negedge clock);
            k++;
            if (get_rdy(w8) === 1'b1) seen = 1'b1;
        end
        edges = seen ? k : -1;
        n_checks++;
        if (edges != (w8 ? 9 : 33)) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges, expected %0d", tag, edges, w8 ? 9 : 33);
        end
    endtask

    // Full operation: start, scramble operands while busy, check pulse and results
    task automatic run_op(input bit w8, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] er, eh;
        logic        ee;
        int          edges;
        model(w8, m, a, b, er, eh, ee);
        @(negedge clock);
        drive(w8, m, d, a, b);
        @(posedge clock);
        @(negedge clock);
        drive(w8, 1'b0, 1'b0, $urandom, $urandom);
        n_checks++;
        if (get_busy(w8) !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_start: got %b, expected 1", tag, get_busy(w8));
        end
        wait_rdy(w8, tag, edges);
        n_checks++;
        if (get_res(w8) !== er || get_hi(w8) !== eh || get_exc(w8) !== ee) begin
            n_fail++;
            $display("FAIL %s result: got res=%h hi=%h exc=%b, expected res=%h hi=%h exc=%b",
                     tag, get_res(w8), get_hi(w8), get_exc(w8), er, eh, ee);
        end
        n_checks++;
        if (get_busy(w8) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_at_rdy: got %b, expected 0", tag, get_busy(w8));
        end
        @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (get_rdy(w8) !== 1'b0 || get_busy(w8) !== 1'b0 || get_res(w8) !== er || get_hi(w8) !== eh) begin
            n_fail++;
            $display("FAIL %s after_pulse: got rdy=%b busy=%b res=%h hi=%h, expected rdy=0 busy=0 res=%h hi=%h",
                     tag, get_rdy(w8), get_busy(w8), get_res(w8), get_hi(w8), er, eh);
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (get_res(i[0]) !== 32'd0 || get_hi(i[0]) !== 32'd0 || get_exc(i[0]) !== 1'b0 ||
                get_rdy(i[0]) !== 1'b0 || get_busy(i[0]) !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state w8=%0d: got res=%h hi=%h exc=%b rdy=%b busy=%b, expected all 0",
                         i, get_res(i[0]), get_hi(i[0]), get_exc(i[0]), get_rdy(i[0]), get_busy(i[0]));
            end
        end
    endtask

    task automatic test_directed();
        run_op(1'b0, 1'b1, 1'b0, 32'd7, -32'sd6, "mult_7_x_m6");
        run_op(1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, "mult_ovf");
        run_op(1'b0, 1'b0, 1'b1, -32'sd7, 32'd2, "div_m7_by_2");
        run_op(1'b0, 1'b0, 1'b1, 32'd5, 32'd0, "div_by_zero");
        run_op(1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_by_m1");
        run_op(1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "mult_min_by_m1");
        run_op(1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd1, "div_min_by_1");
    endtask

    task automatic test_random32();
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
            b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
            if (i % 2 == 0) run_op(1'b0, 1'b1, 1'b0, a, b, "rand_mult32");
            else            run_op(1'b0, 1'b0, 1'b1, a, b, "rand_div32");
        end
    endtask

    task automatic test_width8();
        logic [31:0] a, b;
        run_op(1'b1, 1'b1, 1'b0, 32'h7F, 32'h02, "w8_mult_7f_x_2");
        run_op(1'b1, 1'b0, 1'b1, 32'h80, 32'hFF, "w8_div_min_by_m1");
        run_op(1'b1, 1'b0, 1'b1, 32'h35, 32'h00, "w8_div_by_zero");
        for (int i = 0; i < 20; i++) begin
            a = 32'($urandom_range(0, 255));
            b = 32'($urandom_range(0, 255));
            if (i % 2 == 0) run_op(1'b1, 1'b1, 1'b0, a, b, "rand_mult8");
            else            run_op(1'b1, 1'b0, 1'b1, a, b, "rand_div8");
        end
    endtask

    task automatic test_both_starts();
        run_op(1'b1, 1'b1, 1'b1, 32'h13, 32'h05, "w8_both_high");
        run_op(1'b0, 1'b1, 1'b1, 32'd100, 32'd7, "w32_both_high");
    endtask

    task automatic test_restart();
        int  edges;
        bit  early;
        early = 1'b0;
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 32'd3, 32'd4);
        @(posedge clock);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
        for (int k = 1; k < 10; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (get_rdy(1'b0) === 1'b1) early = 1'b1;
        end
        drive(1'b0, 1'b0, 1'b1, 32'd100, 32'd7);
        @(posedge clock);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        wait_rdy(1'b0, "restart", edges);
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL restart_no_mult_pulse: got rdy=1 before abort, expected 0");
        end
        n_checks++;
        if (get_res(1'b0) !== 32'd14 || get_hi(1'b0) !== 32'd2 || get_exc(1'b0) !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_result: got res=%h hi=%h exc=%b, expected res=0000000e hi=00000002 exc=0",
                     get_res(1'b0), get_hi(1'b0), get_exc(1'b0));
        end
    endtask

    task automatic test_held_start();
        logic [31:0] er, eh;
        logic        ee;
        int          edges;
        model(1'b0, 1'b1, 32'd1234, -32'sd77, er, eh, ee);
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 32'd11, 32'd11);
        @(posedge clock);
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 32'd22, 32'd22);
        @(posedge clock);
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 32'd1234, -32'sd77);
        @(posedge clock);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        wait_rdy(1'b0, "held_start", edges);
        n_checks++;
        if (get_res(1'b0) !== er || get_hi(1'b0) !== eh || get_exc(1'b0) !== ee) begin
            n_fail++;
            $display("FAIL held_start_result: got res=%h hi=%h exc=%b, expected res=%h hi=%h exc=%b",
                     get_res(1'b0), get_hi(1'b0), get_exc(1'b0), er, eh, ee);
        end
    endtask

    task automatic test_reset_mid_op();
        bit pulse;
        pulse = 1'b0;
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 32'd5, 32'd5);
        @(posedge clock);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (5) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (get_res(1'b0) !== 32'd0 || get_hi(1'b0) !== 32'd0 || get_exc(1'b0) !== 1'b0 ||
            get_busy(1'b0) !== 1'b0 || get_rdy(1'b0) !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_op: got res=%h hi=%h exc=%b busy=%b rdy=%b, expected all 0",
                     get_res(1'b0), get_hi(1'b0), get_exc(1'b0), get_busy(1'b0), get_rdy(1'b0));
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (get_rdy(1'b0) === 1'b1 || get_busy(1'b0) === 1'b1) pulse = 1'b1;
        end
        n_checks++;
        if (pulse) begin
            n_fail++;
            $display("FAIL reset_no_pulse: got rdy/busy activity after reset, expected none");
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        test_reset();
        test_directed();
        test_random32();
        test_width8();
        test_both_starts();
        test_restart();
        test_held_start();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
